// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Shares one external combinational 32-bit ALU between N_REQ requesters.
//   Requests are accepted with a round-robin grant on a valid/ready handshake.
//   The accepted operands are registered toward the ALU, and the result is
//   captured one cycle later into a registered response that carries the
//   requester ID. Only one transaction is in flight at a time (IDLE -> EXEC -> RESP).
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot and combinational
//   req_op/req_a/req_b     packed per-requester ALUCtl (3b) and operands (32b)
//   alu_ctl/alu_a/alu_b    registered drive to the ALU
//   alu_result/alu_zero    ALU outputs, captured in EXEC
//   resp_valid/resp_ready  response handshake
//   resp_id/resp_result/resp_zero  registered response payload
//   grant_cnt              per-requester saturating accept counters (ALU_ARB_STATS_EN only)
//
// Configuration
//   ALU_ARB_STATS_EN       define to add the grant_cnt port and its counters

module alu_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned ID_W = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [3*N_REQ-1:0]    req_op,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [2:0]            alu_ctl,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    input  logic [31:0]           alu_result,
    input  logic                  alu_zero,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_result,
    output logic                  resp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W*N_REQ-1:0] grant_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            accept;
    int unsigned     cand;

    logic [2:0]      op_arr [N_REQ];
    logic [31:0]     a_arr  [N_REQ];
    logic [31:0]     b_arr  [N_REQ];

    // Unpack the flat request buses into per-requester arrays
    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[3*g +: 3];
        assign a_arr[g]  = req_a[32*g +: 32];
        assign b_arr[g]  = req_b[32*g +: 32];
    end

    // Round-robin search: first valid requester after ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Grants are offered only in IDLE and never while reset is asserted
    assign accept    = (state == IDLE) && !reset && grant_found;
    assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch on accept, result capture in EXEC, response handshake in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= ID_W'(N_REQ - 1);
            owner       <= '0;
            alu_ctl     <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                alu_ctl <= op_arr[grant_idx];
                alu_a   <= a_arr[grant_idx];
                alu_b   <= b_arr[grant_idx];
                owner   <= grant_idx;
                ptr     <= grant_idx;
            end
            if (state == EXEC) begin
                resp_valid  <= 1'b1;
                resp_id     <= owner;
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
            end
            if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-requester saturating accept counters
    for (genvar g = 0; g < N_REQ; g++) begin : g_stats
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
            end else if (accept && grant_idx == ID_W'(g) && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign grant_cnt[CNT_W*g +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter
//   Directed bench for alu_rr_arbiter with N_REQ=2. Provides a reference ALU
//   model on the alu_* bus, applies a table of single transactions, then
//   hand-written sequences for backpressure, request withdrawal, reset during
//   EXEC and (with ALU_ARB_STATS_EN) counter saturation at CNT_W=2.

module tb_alu_rr_arbiter;

    localparam int unsigned N_REQ = 2;
`ifdef ALU_ARB_STATS_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 16;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [5:0]   req_op;
    logic [63:0]  req_a;
    logic [63:0]  req_b;
    logic [2:0]   alu_ctl;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [31:0]  alu_result;
    logic         alu_zero;
    logic         resp_valid;
    logic         resp_ready;
    logic [0:0]   resp_id;
    logic [31:0]  resp_result;
    logic         resp_zero;
`ifdef ALU_ARB_STATS_EN
    logic [CNT_W*N_REQ-1:0] grant_cnt;
`endif

    logic [2:0]   op0, op1;
    logic [31:0]  a0, a1, b0, b1;

    assign req_op = {op1, op0};
    assign req_a  = {a1, a0};
    assign req_b  = {b1, b0};

    always #5 clk = ~clk;

    alu_rr_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_ctl     (alu_ctl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt   (grant_cnt)
`endif
    );

    // Reference combinational ALU sitting on the arbiter's ALU bus
    always_comb begin
        case (alu_ctl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    typedef struct {
        logic [1:0]  valid;
        logic [2:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [2:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [0:0]  id;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid = v.valid;
        op0 = v.op0; a0 = v.a0; b0 = v.b0;
        op1 = v.op1; a1 = v.a1; b1 = v.b1;
    endtask

    initial begin
        // valid, op0, a0, b0, op1, a1, b1, id, res, zero
        vecs[0] = '{2'b01, 3'b000, 32'd5,        32'd7,      3'b000, 32'd0,      32'd0,      1'b0, 32'd12,     1'b0};
        vecs[1] = '{2'b11, 3'b001, 32'd3,        32'd3,      3'b001, 32'd3,      32'd3,      1'b1, 32'd0,      1'b1};
        vecs[2] = '{2'b11, 3'b001, 32'd3,        32'd3,      3'b001, 32'd3,      32'd3,      1'b0, 32'd0,      1'b1};
        vecs[3] = '{2'b11, 3'b001, 32'd3,        32'd3,      3'b001, 32'd3,      32'd3,      1'b1, 32'd0,      1'b1};
        vecs[4] = '{2'b10, 3'b000, 32'd0,        32'd0,      3'b100, 32'd2,      32'd9,      1'b1, 32'd1,      1'b0};
        vecs[5] = '{2'b01, 3'b111, 32'hFFFFFFFF, 32'd1,      3'b000, 32'd0,      32'd0,      1'b0, 32'd0,      1'b1};
        vecs[6] = '{2'b10, 3'b000, 32'd0,        32'd0,      3'b011, 32'h000000F0, 32'h0000000F, 1'b1, 32'h000000FF, 1'b0};
        vecs[7] = '{2'b11, 3'b010, 32'h0000FF00, 32'h00000FF0, 3'b000, 32'd1,   32'd1,      1'b0, 32'h00000F00, 1'b0};
        vecs[8] = '{2'b11, 3'b000, 32'd1,        32'd1,      3'b100, 32'hFFFFFFFF, 32'd1,   1'b1, 32'd1,      1'b0};
        vecs[9] = '{2'b01, 3'b001, 32'd10,       32'd3,      3'b000, 32'd0,      32'd0,      1'b0, 32'd7,      1'b0};

        reset = 1'b1;
        resp_ready = 1'b1;
        req_valid = 2'b01;
        op0 = 3'b000; a0 = 32'd5; b0 = 32'd7;
        op1 = 3'b000; a1 = 32'd0; b1 = 32'd0;

        // Reset state
        @(negedge clk);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_ctl", 32'(alu_ctl), 32'd0);
        reset = 1'b0;

        // Table: one transaction per row, responses consumed immediately
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(2'b01 << vecs[i].id));
            @(negedge clk);
            check($sformatf("v%0d_exec_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("v%0d_exec_rvalid", i), 32'(resp_valid), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_rvalid", i), 32'(resp_valid), 32'd1);
            check($sformatf("v%0d_id", i), 32'(resp_id), 32'(vecs[i].id));
            check($sformatf("v%0d_result", i), resp_result, vecs[i].res);
            check($sformatf("v%0d_zero", i), 32'(resp_zero), 32'(vecs[i].zero));
            @(negedge clk);
        end

        // Backpressure: req1 slt 2<9 held for 5 cycles with resp_ready low
        resp_ready = 1'b0;
        req_valid = 2'b11;
        op0 = 3'b000; a0 = 32'd1; b0 = 32'd2;
        op1 = 3'b100; a1 = 32'd2; b1 = 32'd9;
        #1;
        check("bp_ready", 32'(req_ready), 32'b10);
        @(negedge clk);
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_rvalid", k), 32'(resp_valid), 32'd1);
            check($sformatf("bp%0d_result", k), resp_result, 32'd1);
            check($sformatf("bp%0d_id", k), 32'(resp_id), 32'd1);
            check($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", 32'(req_ready), 32'b01);
        check("bp_rvalid_clr", 32'(resp_valid), 32'd0);
        check("bp_result_kept", resp_result, 32'd1);
        // Withdraw before accept: no grant, pointer unchanged
        req_valid = 2'b00;
        @(negedge clk);
        check("drop_ready", 32'(req_ready), 32'd0);
        check("drop_rvalid", 32'(resp_valid), 32'd0);
        req_valid = 2'b11;
        #1;
        check("drop_ptr_kept", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        @(negedge clk);

        // Reset while in EXEC discards the transaction and restores pointer
        req_valid = 2'b01;
        op0 = 3'b000; a0 = 32'd1; b0 = 32'd2;
        #1;
        check("rx_ready", 32'(req_ready), 32'b01);
        @(negedge clk);
        reset = 1'b1;
        req_valid = 2'b11;
        #1;
        check("rx_ready_in_reset", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rx_rvalid", 32'(resp_valid), 32'd0);
        check("rx_result", resp_result, 32'd0);
        check("rx_alu_a", alu_a, 32'd0);
        #1;
        check("rx_first_grant", 32'(req_ready), 32'b01);
        req_valid = 2'b00;
        @(negedge clk);
        check("rx_rvalid_later", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("rx_rvalid_later2", 32'(resp_valid), 32'd0);

`ifdef ALU_ARB_STATS_EN
        // Counter saturation at CNT_W=2
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("cnt_rst", 32'(grant_cnt), 32'd0);
        begin
            logic [1:0] exp_cnt [5];
            exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
            exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
            for (int k = 0; k < 5; k++) begin
                req_valid = 2'b01;
                op0 = 3'b000; a0 = 32'(k); b0 = 32'd1;
                #1;
                check($sformatf("cnt%0d_ready", k), 32'(req_ready), 32'b01);
                @(negedge clk);
                @(negedge clk);
                check($sformatf("cnt%0d_c0", k), 32'(grant_cnt[1:0]), 32'(exp_cnt[k]));
                check($sformatf("cnt%0d_c1", k), 32'(grant_cnt[3:2]), 32'd0);
                @(negedge clk);
            end
            req_valid = 2'b00;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
